tron_move_scheduler: RTL and testbench

- Per-tick game sequencer for the two-player TRON datapath.
- Buffers each player's requested direction between game ticks and commits it under the no-reversal rule.
- Steps both heads one cell per tick, checks walls, head-on hits and trail occupancy through the shared trail-memory port, and decides the winner.
- Arbitrates the single VGA plotter so each tick draws P1 first, then P2. Sits between keyboard/switch decode, the rate-divider tick, the trail memory and the plotter.

---
 rtl/tron_pkg.sv | 46 ++++
 rtl/tron_next_pos.sv | 51 +++++
 rtl/tron_move_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_tron_move_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// ============================================================================
// Module      : tron_pkg
// Description : Shared encodings for the two-player TRON move scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tron_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b11;
    localparam logic [1:0] DIR_LEFT  = 2'b10;

    localparam logic [2:0] COL_P1 = 3'b100;
    localparam logic [2:0] COL_P2 = 3'b001;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int GRID_W_DEF = 160;
    localparam int GRID_H_DEF = 120;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_INIT    = 4'd1,
        S_RUN     = 4'd2,
        S_MOVE    = 4'd3,
        S_CHK1    = 4'd4,
        S_CHK2    = 4'd5,
        S_RESOLVE = 4'd6,
        S_PLOT1   = 4'd7,
        S_PLOT2   = 4'd8,
        S_OVER    = 4'd9
    } state_e;

    // Opposite directions differ in both bits.
    function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] req);
        return req == (cur ^ 2'b11);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tron_next_pos.sv
// ============================================================================
// Module      : tron_next_pos
// Description : One-cell step of a head in a given direction, with wall flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tron_next_pos
    import tron_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    parameter int X_W    = 8,
    parameter int Y_W    = 7
) (
    input  logic [X_W-1:0] x_i,
    input  logic [Y_W-1:0] y_i,
    input  logic [1:0]     dir_i,
    output logic [X_W-1:0] nx_o,
    output logic [Y_W-1:0] ny_o,
    output logic           wall_o
);

    // On a wall the position is left as-is; the wall flag alone decides death.
    always_comb begin
        nx_o   = x_i;
        ny_o   = y_i;
        wall_o = 1'b0;
        case (dir_i)
            DIR_UP: begin
                if (y_i == '0) wall_o = 1'b1;
                else           ny_o   = y_i - Y_W'(1);
            end
            DIR_DOWN: begin
                if (y_i == Y_W'(GRID_H - 1)) wall_o = 1'b1;
                else                         ny_o   = y_i + Y_W'(1);
            end
            DIR_LEFT: begin
                if (x_i == '0) wall_o = 1'b1;
                else           nx_o   = x_i - X_W'(1);
            end
            default: begin
                if (x_i == X_W'(GRID_W - 1)) wall_o = 1'b1;
                else                         nx_o   = x_i + X_W'(1);
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tron_move_scheduler.sv
// ============================================================================
// Module      : tron_move_scheduler
// Description : Per-tick TRON sequencer: direction commit, collision checks
//               via trail memory, winner decision and plotter arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tron_move_scheduler
    import tron_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int P1_X0  = 80,
    parameter int P1_Y0  = 10,
    parameter int P2_X0  = 80,
    parameter int P2_Y0  = 109
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           tick,
    input  logic [1:0]     p1_dir_req,
    input  logic           p1_dir_valid,
    input  logic [1:0]     p2_dir_req,
    input  logic           p2_dir_valid,
    output logic           occ_rd_req,
    output logic [X_W-1:0] occ_x,
    output logic [Y_W-1:0] occ_y,
    input  logic           occ_rd_ack,
    input  logic           occ_hit,
    output logic           plot_req,
    output logic [X_W-1:0] plot_x,
    output logic [Y_W-1:0] plot_y,
    output logic [2:0]     plot_color,
    input  logic           plot_ack,
    output logic [X_W-1:0] p1_x,
    output logic [Y_W-1:0] p1_y,
    output logic [X_W-1:0] p2_x,
    output logic [Y_W-1:0] p2_y,
    output logic           running,
    output logic           game_over,
    output logic [1:0]     winner
);

    localparam logic [X_W-1:0] P1_XS = X_W'(P1_X0);
    localparam logic [Y_W-1:0] P1_YS = Y_W'(P1_Y0);
    localparam logic [X_W-1:0] P2_XS = X_W'(P2_X0);
    localparam logic [Y_W-1:0] P2_YS = Y_W'(P2_Y0);

    state_e         state_q;
    logic [X_W-1:0] p1_x_q, p2_x_q, n1_x_q, n2_x_q, occ_x_q, plot_x_q;
    logic [Y_W-1:0] p1_y_q, p2_y_q, n1_y_q, n2_y_q, occ_y_q, plot_y_q;
    logic [1:0]     p1_dir_q, p2_dir_q, p1_pend_q, p2_pend_q, winner_q;
    logic [2:0]     plot_col_q;
    logic           wall1_q, wall2_q, hit1_q, hit2_q;
    logic           occ_req_q, plot_req_q, running_q, game_over_q;

    logic [1:0]     p1_dir_d, p2_dir_d;
    logic [X_W-1:0] w_n1_x, w_n2_x;
    logic [Y_W-1:0] w_n1_y, w_n2_y;
    logic           w_wall1, w_wall2, w_headon, w_die1, w_die2;

    assign p1_dir_d = is_reversal(p1_dir_q, p1_pend_q) ? p1_dir_q : p1_pend_q;
    assign p2_dir_d = is_reversal(p2_dir_q, p2_pend_q) ? p2_dir_q : p2_pend_q;

    tron_next_pos #(.GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W)) u_next_p1 (
        .x_i(p1_x_q), .y_i(p1_y_q), .dir_i(p1_dir_d),
        .nx_o(w_n1_x), .ny_o(w_n1_y), .wall_o(w_wall1)
    );

    tron_next_pos #(.GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W)) u_next_p2 (
        .x_i(p2_x_q), .y_i(p2_y_q), .dir_i(p2_dir_d),
        .nx_o(w_n2_x), .ny_o(w_n2_y), .wall_o(w_wall2)
    );

    // Head-on: same target cell, or the two heads trading places.
    assign w_headon = !wall1_q && !wall2_q &&
                      (((n1_x_q == n2_x_q) && (n1_y_q == n2_y_q)) ||
                       ((n1_x_q == p2_x_q) && (n1_y_q == p2_y_q) &&
                        (n2_x_q == p1_x_q) && (n2_y_q == p1_y_q)));
    assign w_die1 = wall1_q || hit1_q || w_headon;
    assign w_die2 = wall2_q || hit2_q || w_headon;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            p1_x_q      <= P1_XS;
            p1_y_q      <= P1_YS;
            p2_x_q      <= P2_XS;
            p2_y_q      <= P2_YS;
            p1_dir_q    <= DIR_DOWN;
            p2_dir_q    <= DIR_UP;
            p1_pend_q   <= DIR_DOWN;
            p2_pend_q   <= DIR_UP;
            n1_x_q      <= '0;
            n1_y_q      <= '0;
            n2_x_q      <= '0;
            n2_y_q      <= '0;
            wall1_q     <= 1'b0;
            wall2_q     <= 1'b0;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            occ_req_q   <= 1'b0;
            occ_x_q     <= '0;
            occ_y_q     <= '0;
            plot_req_q  <= 1'b0;
            plot_x_q    <= '0;
            plot_y_q    <= '0;
            plot_col_q  <= 3'b000;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            case (state_q)
                S_IDLE: if (start) state_q <= S_INIT;
                S_INIT: begin
                    p1_x_q      <= P1_XS;
                    p1_y_q      <= P1_YS;
                    p2_x_q      <= P2_XS;
                    p2_y_q      <= P2_YS;
                    p1_dir_q    <= DIR_DOWN;
                    p2_dir_q    <= DIR_UP;
                    p1_pend_q   <= DIR_DOWN;
                    p2_pend_q   <= DIR_UP;
                    winner_q    <= WIN_NONE;
                    running_q   <= 1'b1;
                    game_over_q <= 1'b0;
                    state_q     <= S_PLOT1;
                end
                S_RUN: if (tick) state_q <= S_MOVE;
                S_MOVE: begin
                    p1_dir_q <= p1_dir_d;
                    p2_dir_q <= p2_dir_d;
                    n1_x_q   <= w_n1_x;
                    n1_y_q   <= w_n1_y;
                    n2_x_q   <= w_n2_x;
                    n2_y_q   <= w_n2_y;
                    wall1_q  <= w_wall1;
                    wall2_q  <= w_wall2;
                    hit1_q   <= 1'b0;
                    hit2_q   <= 1'b0;
                    if (!w_wall1) begin
                        occ_req_q <= 1'b1;
                        occ_x_q   <= w_n1_x;
                        occ_y_q   <= w_n1_y;
                        state_q   <= S_CHK1;
                    end else begin
                        state_q   <= S_CHK2;
                    end
                end
                S_CHK1: begin
                    if (occ_rd_ack) begin
                        occ_req_q <= 1'b0;
                        hit1_q    <= occ_hit;
                        state_q   <= S_CHK2;
                    end
                end
                S_CHK2: begin
                    if (!occ_req_q) begin
                        if (wall2_q) begin
                            state_q <= S_RESOLVE;
                        end else begin
                            occ_req_q <= 1'b1;
                            occ_x_q   <= n2_x_q;
                            occ_y_q   <= n2_y_q;
                        end
                    end else if (occ_rd_ack) begin
                        occ_req_q <= 1'b0;
                        hit2_q    <= occ_hit;
                        state_q   <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    if (!w_die1 && !w_die2) begin
                        p1_x_q  <= n1_x_q;
                        p1_y_q  <= n1_y_q;
                        p2_x_q  <= n2_x_q;
                        p2_y_q  <= n2_y_q;
                        state_q <= S_PLOT1;
                    end else begin
                        // {die1, die2} maps directly onto the winner code.
                        winner_q    <= {w_die1, w_die2};
                        running_q   <= 1'b0;
                        game_over_q <= 1'b1;
                        state_q     <= S_OVER;
                    end
                end
                S_PLOT1: begin
                    if (!plot_req_q) begin
                        plot_req_q <= 1'b1;
                        plot_x_q   <= p1_x_q;
                        plot_y_q   <= p1_y_q;
                        plot_col_q <= COL_P1;
                    end else if (plot_ack) begin
                        plot_req_q <= 1'b0;
                        state_q    <= S_PLOT2;
                    end
                end
                S_PLOT2: begin
                    if (!plot_req_q) begin
                        plot_req_q <= 1'b1;
                        plot_x_q   <= p2_x_q;
                        plot_y_q   <= p2_y_q;
                        plot_col_q <= COL_P2;
                    end else if (plot_ack) begin
                        plot_req_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_OVER: if (start) state_q <= S_INIT;
                default: state_q <= S_IDLE;
            endcase

            // A fresh request always lands in the pending slot, even during INIT.
            if (p1_dir_valid) p1_pend_q <= p1_dir_req;
            if (p2_dir_valid) p2_pend_q <= p2_dir_req;
        end
    end

    assign occ_rd_req = occ_req_q;
    assign occ_x      = occ_x_q;
    assign occ_y      = occ_y_q;
    assign plot_req   = plot_req_q;
    assign plot_x     = plot_x_q;
    assign plot_y     = plot_y_q;
    assign plot_color = plot_col_q;
    assign p1_x       = p1_x_q;
    assign p1_y       = p1_y_q;
    assign p2_x       = p2_x_q;
    assign p2_y       = p2_y_q;
    assign running    = running_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_tron_move_scheduler.sv
// ============================================================================
// Module      : tb_tron_move_scheduler
// Description : Scoreboard bench for tron_move_scheduler using directed games.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tron_move_scheduler;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } xact_t;

    logic       clk = 1'b0;
    logic       resetn, start, tick;
    logic [1:0] p1_dir_req, p2_dir_req;
    logic       p1_dir_valid, p2_dir_valid;
    logic       occ_rd_req, occ_rd_ack, occ_hit;
    logic [7:0] occ_x, plot_x, p1_x, p2_x;
    logic [6:0] occ_y, plot_y, p1_y, p2_y;
    logic       plot_req, plot_ack;
    logic [2:0] plot_color;
    logic       running, game_over;
    logic [1:0] winner;

    logic       hit_en;
    logic [7:0] hit_x;
    logic [6:0] hit_y;

    int    errors = 0;
    int    checks = 0;
    xact_t plot_q[$];
    xact_t occ_q[$];
    xact_t mon_e;

    always #5 clk = ~clk;

    assign occ_rd_ack = occ_rd_req;
    assign occ_hit    = hit_en && (occ_x == hit_x) && (occ_y == hit_y);

    tron_move_scheduler dut (
        .clk(clk), .resetn(resetn), .start(start), .tick(tick),
        .p1_dir_req(p1_dir_req), .p1_dir_valid(p1_dir_valid),
        .p2_dir_req(p2_dir_req), .p2_dir_valid(p2_dir_valid),
        .occ_rd_req(occ_rd_req), .occ_x(occ_x), .occ_y(occ_y),
        .occ_rd_ack(occ_rd_ack), .occ_hit(occ_hit),
        .plot_req(plot_req), .plot_x(plot_x), .plot_y(plot_y),
        .plot_color(plot_color), .plot_ack(plot_ack),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .running(running), .game_over(game_over), .winner(winner)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=event required=no event", name);
    endtask

    // Monitor: every completed handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (resetn && plot_req && plot_ack) begin
            if (plot_q.size() == 0) fail_now("plot_unexpected");
            else begin
                mon_e = plot_q.pop_front();
                check("plot", {plot_x, plot_y, plot_color}, mon_e);
            end
        end
        if (resetn && occ_rd_req && occ_rd_ack) begin
            if (occ_q.size() == 0) fail_now("occ_unexpected");
            else begin
                mon_e = occ_q.pop_front();
                check("occ_lookup", {occ_x, occ_y, 3'b000}, mon_e);
            end
        end
    end

    task automatic pulse_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic req_p1(input logic [1:0] d);
        @(posedge clk); #1 p1_dir_valid = 1'b1; p1_dir_req = d;
        @(posedge clk); #1 p1_dir_valid = 1'b0;
    endtask

    task automatic push(input bit to_plot, input int x, input int y, input logic [2:0] c);
        xact_t e;
        e = {8'(x), 7'(y), c};
        if (to_plot) plot_q.push_back(e);
        else         occ_q.push_back(e);
    endtask

    task automatic do_start();
        bit done = 0;
        push(1, 80, 10, 3'b100);
        push(1, 80, 109, 3'b001);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (plot_q.size() == 0) begin done = 1; break; end
        end
        if (!done) fail_now("start_timeout");
        check("start_running", running, 1);
        check("start_game_over", game_over, 0);
        check("start_winner", winner, 0);
        repeat (2) @(posedge clk); #1;
    endtask

    // One game step with hand-computed next cells; win=0 means both survive.
    task automatic step(input int x1, input int y1, input bit look1,
                        input int x2, input int y2, input bit look2,
                        input logic [1:0] win, input bit probe);
        bit done = 0;
        if (look1) push(0, x1, y1, 3'b000);
        if (look2) push(0, x2, y2, 3'b000);
        if (win == 2'b00) begin
            push(1, x1, y1, 3'b100);
            push(1, x2, y2, 3'b001);
        end
        pulse_tick();
        if (probe) begin
            repeat (2) @(posedge clk);
            #1 tick = 1'b1; start = 1'b1;
            @(posedge clk); #1 tick = 1'b0; start = 1'b0;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (win == 2'b00 ? (plot_q.size() == 0 && occ_q.size() == 0) : (game_over === 1'b1)) begin
                done = 1;
                break;
            end
        end
        if (!done) fail_now("step_timeout");
        else if (win != 2'b00) begin
            check("winner", winner, win);
            check("over_running", running, 0);
            check("over_lookups_done", occ_q.size(), 0);
        end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic check_heads(input string tag, input int ax, input int ay, input int bx, input int by);
        check({tag, "_p1"}, {p1_x, p1_y}, {8'(ax), 7'(ay)});
        check({tag, "_p2"}, {p2_x, p2_y}, {8'(bx), 7'(by)});
    endtask

    initial begin
        bit seen = 0;
        resetn = 1'b0; start = 1'b0; tick = 1'b0;
        p1_dir_req = 2'b00; p1_dir_valid = 1'b0;
        p2_dir_req = 2'b00; p2_dir_valid = 1'b0;
        plot_ack = 1'b1; hit_en = 1'b0; hit_x = '0; hit_y = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_running", running, 0);
        check("rst_game_over", game_over, 0);
        check("rst_winner", winner, 0);
        check("rst_reqs", {occ_rd_req, plot_req}, 0);
        check_heads("rst", 80, 10, 80, 109);
        resetn = 1'b1;

        // Game A: turn, refused reversal, last-request-wins, then reset mid-plot.
        do_start();
        req_p1(2'b01);
        step(81, 10, 1, 80, 108, 1, 2'b00, 1);
        check_heads("turn_right", 81, 10, 80, 108);
        req_p1(2'b10);
        step(82, 10, 1, 80, 107, 1, 2'b00, 0);
        req_p1(2'b11);
        req_p1(2'b00);
        step(82, 9, 1, 80, 106, 1, 2'b00, 0);
        check_heads("last_wins", 82, 9, 80, 106);

        plot_ack = 1'b0;
        push(0, 82, 8, 3'b000);
        push(0, 80, 105, 3'b000);
        pulse_tick();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (plot_req) begin seen = 1; break; end
        end
        if (!seen) fail_now("plot_wait_timeout");
        #2 resetn = 1'b0;
        #1;
        check("rst_async_plot_req", plot_req, 0);
        check("rst_async_running", running, 0);
        check_heads("rst_async", 80, 10, 80, 109);
        check("rst_async_lookups", occ_q.size(), 0);
        repeat (2) @(posedge clk); #1;
        plot_ack = 1'b1;
        resetn = 1'b1;
        pulse_tick();
        repeat (5) @(posedge clk); #1;
        check("idle_ignores_tick", running, 0);

        // Game B: reversal from DOWN refused, then a swap head-on draw.
        do_start();
        req_p1(2'b00);
        step(80, 11, 1, 80, 108, 1, 2'b00, 0);
        for (int k = 1; k <= 48; k++) step(80, 11 + k, 1, 80, 108 - k, 1, 2'b00, 0);
        step(80, 60, 1, 80, 59, 1, 2'b11, 0);
        check_heads("swap", 80, 59, 80, 60);
        check("swap_game_over", game_over, 1);

        // Game C: trail hit on P2's next cell only.
        do_start();
        hit_x = 8'd80; hit_y = 7'd108; hit_en = 1'b1;
        step(80, 11, 1, 80, 108, 1, 2'b01, 0);
        hit_en = 1'b0;
        check_heads("occ_hit", 80, 10, 80, 109);

        // Game D: P1 runs into the left wall.
        do_start();
        req_p1(2'b10);
        for (int i = 1; i <= 80; i++) step(80 - i, 10, 1, 80, 109 - i, 1, 2'b00, 0);
        step(0, 10, 0, 80, 28, 1, 2'b10, 0);
        check_heads("wall", 0, 10, 80, 29);
        check("wall_game_over", game_over, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
